// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: N writeback requesters share we3/a3/wd3
// through one registered output stage, with a saturating contention counter.
module rf_wb_arbiter #(
    parameter int N     = 2,
    parameter int RR    = 1,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*5-1:0]    req_addr,
    input  logic [N*32-1:0]   req_data,
    output logic              we3,
    output logic [4:0]        a3,
    output logic [31:0]       wd3,
    output logic [2:0]        grant_id,
    output logic [CNT_W-1:0]  contention
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0]    r_ptr;
    logic             r_we;
    logic [4:0]       r_a;
    logic [31:0]      r_wd;
    logic [2:0]       r_gid;
    logic [CNT_W-1:0] r_cnt;

    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    w_win;
    logic             w_any;
    logic             w_xfer;
    logic             w_busy;
    logic [4:0]       w_addr;
    logic [31:0]      w_data;

    // Search order begins just after the last winner; fixed mode scans from 0.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (RR != 0) begin
                if (int'(r_ptr) + k + 1 >= N)
                    w_idx = IW'(int'(r_ptr) + k + 1 - N);
                else
                    w_idx = IW'(int'(r_ptr) + k + 1);
            end else begin
                w_idx = IW'(k);
            end
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win == IW'(i)) begin
                w_addr = req_addr[i*5 +: 5];
                w_data = req_data[i*32 +: 32];
            end
        end
    end

    assign w_xfer    = w_any & ~hold & ~reset;
    assign w_busy    = ~hold & ($countones(req_valid) >= 2);
    assign req_ready = w_xfer ? (N'(1) << w_win) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we  <= 1'b0;
            r_a   <= '0;
            r_wd  <= '0;
            r_gid <= '0;
            r_cnt <= '0;
            r_ptr <= IW'(N - 1);
        end else begin
            // x0 targets are accepted but never enabled onto the write port
            r_we <= w_xfer && (w_addr != 5'd0);
            if (w_xfer) begin
                r_a   <= w_addr;
                r_wd  <= w_data;
                r_gid <= 3'(w_win);
                r_ptr <= w_win;
            end
            if (w_busy && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign we3        = r_we;
    assign a3         = r_a;
    assign wd3        = r_wd;
    assign grant_id   = r_gid;
    assign contention = r_cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed cases plus randomized traffic against
// a behavioural model, round-robin and fixed-priority instances side by side.
module tb_rf_wb_arbiter;

    localparam int NR = 2;

    logic          clk;
    logic          reset;
    logic          hold;
    logic [1:0]    req_valid;
    logic [9:0]    req_addr;
    logic [63:0]   req_data;

    logic [1:0]    req_ready;
    logic          we3;
    logic [4:0]    a3;
    logic [31:0]   wd3;
    logic [2:0]    grant_id;
    logic [15:0]   contention;

    logic [1:0]    f_ready;
    logic          f_we3;
    logic [4:0]    f_a3;
    logic [31:0]   f_wd3;
    logic [2:0]    f_gid;
    logic [2:0]    f_cnt;

    int errors = 0;
    int checks = 0;

    rf_wb_arbiter #(.N(2), .RR(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .we3(we3), .a3(a3), .wd3(wd3),
        .grant_id(grant_id), .contention(contention)
    );

    rf_wb_arbiter #(.N(2), .RR(0), .CNT_W(3)) dut_fp (
        .clk(clk), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(f_ready),
        .req_addr(req_addr), .req_data(req_data),
        .we3(f_we3), .a3(f_a3), .wd3(f_wd3),
        .grant_id(f_gid), .contention(f_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [1:0] v, input int ptr, input bit rr);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = rr ? (ptr + k) % NR : k - 1;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [1:0] onehot(input int g);
        if (g < 0) return 2'b00;
        return 2'(1 << g);
    endfunction

    int          m_ptr;
    int          m_last;
    bit          m_we;
    bit [4:0]    m_a;
    bit [31:0]   m_wd;
    bit [2:0]    m_gid;
    int          m_cnt;
    bit          mf_we;
    bit [4:0]    mf_a;
    bit [31:0]   mf_wd;
    bit [2:0]    mf_gid;
    int          mf_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ptr = NR - 1; m_last = -1;
            m_we = 0; m_a = 0; m_wd = 0; m_gid = 0; m_cnt = 0;
            mf_we = 0; mf_a = 0; mf_wd = 0; mf_gid = 0; mf_cnt = 0;
        end else begin
            int g;
            int gf;
            g  = hold ? -1 : pick(req_valid, m_ptr, 1'b1);
            gf = hold ? -1 : pick(req_valid, 0, 1'b0);
            if (g >= 0) begin
                m_a   = req_addr[g*5 +: 5];
                m_we  = (m_a != 0);
                m_wd  = req_data[g*32 +: 32];
                m_gid = 3'(g);
                m_ptr = g;
            end else begin
                m_we = 0;
            end
            if (gf >= 0) begin
                mf_a   = req_addr[gf*5 +: 5];
                mf_we  = (mf_a != 0);
                mf_wd  = req_data[gf*32 +: 32];
                mf_gid = 3'(gf);
            end else begin
                mf_we = 0;
            end
            if (!hold && $countones(req_valid) >= 2) begin
                if (m_cnt < 65535) m_cnt++;
                if (mf_cnt < 7) mf_cnt++;
            end
            m_last = g;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("rr_ready", req_ready,
                hold ? 2'b00 : onehot(pick(req_valid, m_ptr, 1'b1)));
            chk("rr_we3", we3, m_we);
            chk("rr_a3", a3, m_a);
            chk("rr_wd3", wd3, m_wd);
            chk("rr_gid", grant_id, m_gid);
            chk("rr_cnt", contention, m_cnt);
            chk("fp_ready", f_ready,
                hold ? 2'b00 : onehot(pick(req_valid, 0, 1'b0)));
            chk("fp_we3", f_we3, mf_we);
            chk("fp_a3", f_a3, mf_a);
            chk("fp_wd3", f_wd3, mf_wd);
            chk("fp_gid", f_gid, mf_gid);
            chk("fp_cnt", f_cnt, mf_cnt);
        end
    end

    initial begin
        reset = 1'b1; hold = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_we3", we3, 0);
        chk("rst_a3", a3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_cnt", contention, 0);

        // single requester
        req_valid = 2'b01;
        req_addr  = {5'd0, 5'd5};
        req_data  = {32'h0, 32'hDEADBEEF};
        #1 chk("t2_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("t2_we3", we3, 1);
        chk("t2_a3", a3, 5);
        chk("t2_wd3", wd3, 32'hDEADBEEF);
        chk("t2_gid", grant_id, 0);
        tick();
        chk("t2_idle_we3", we3, 0);

        // fairness and fixed priority from a fresh pointer
        reset = 1'b1;
        #1 reset = 1'b0;
        req_valid = 2'b11;
        req_addr  = {5'd9, 5'd7};
        req_data  = {32'hB, 32'hA};
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t3_ready", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            chk("t4_fp_ready", f_ready, 2'b01);
            tick();
            chk("t3_gid", grant_id, c % 2);
            chk("t3_we3", we3, 1);
            chk("t3_a3", a3, (c % 2 == 0) ? 7 : 9);
            chk("t4_fp_gid", f_gid, 0);
        end
        chk("t3_cnt", contention, 4);
        chk("t4_fp_cnt", f_cnt, 4);

        // hold with both valid
        hold = 1'b1;
        #1 chk("t6_inflight_we3", we3, 1);
        for (int h = 0; h < 2; h++) begin
            chk("t6_ready", req_ready, 2'b00);
            tick();
            chk("t6_we3", we3, 0);
        end
        chk("t6_cnt", contention, 4);
        hold = 1'b0;
        #1 chk("t6_release_ready", req_ready, 2'b01);
        tick();
        chk("t6_release_gid", grant_id, 0);
        chk("t6_cnt_after", contention, 5);

        // async reset while a write is in the output stage
        #1 chk("t1_pre_we3", we3, 1);
        reset = 1'b1;
        #1;
        chk("t1_we3", we3, 0);
        chk("t1_a3", a3, 0);
        chk("t1_wd3", wd3, 0);
        chk("t1_gid", grant_id, 0);
        chk("t1_cnt", contention, 0);
        chk("t1_ready", req_ready, 2'b00);
        reset = 1'b0;

        // write to x0
        req_valid = 2'b10;
        req_addr  = {5'd0, 5'd3};
        req_data  = {32'h1234, 32'h0};
        #1 chk("t5_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("t5_we3", we3, 0);
        chk("t5_a3", a3, 0);
        chk("t5_wd3", wd3, 32'h1234);
        chk("t5_gid", grant_id, 1);

        // randomized traffic obeying the valid/ready protocol
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && m_last == i)
                    req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i*5 +: 5]   = 5'($urandom_range(0, 31));
                    req_data[i*32 +: 32] = $urandom;
                end
            end
            hold = ($urandom_range(0, 9) == 0);
            if (n == 1500) begin
                reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
